// File: rtl/colour_pkg.sv
// Shared types, constants and the colour step rule for the colour sequencer.
package colour_pkg;

   localparam int unsigned COL_W = 3;

   typedef logic [COL_W-1:0] colour_t;

   localparam colour_t COL_OFF  = '0;
   localparam logic    DIR_UP   = 1'b0;
   localparam logic    DIR_DOWN = 1'b1;

   typedef struct packed {
      colour_t colour;
      logic    wrap;
   } next_t;

   // One step from c; the range ends are compared before any arithmetic so nothing overflows.
   function automatic next_t next_colour(colour_t c, logic dir, colour_t min, colour_t max);
      next_t r;
      r.colour = c;
      r.wrap   = 1'b0;
      if (c == COL_OFF) begin
         r.colour = (dir == DIR_DOWN) ? max : min;
      end else if (dir == DIR_UP) begin
         if (c == max) begin
            r.colour = min;
            r.wrap   = 1'b1;
         end else begin
            r.colour = c + colour_t'(1);
         end
      end else begin
         if (c == min) begin
            r.colour = max;
            r.wrap   = 1'b1;
         end else begin
            r.colour = c - colour_t'(1);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/colour_sequencer_if.sv
// Control and colour bus between a panel controller and the colour sequencer.
interface colour_sequencer_if
   import colour_pkg::*;
#(
   parameter int unsigned NUM_CH = 2
);

   logic [NUM_CH-1:0]       button;
   logic                    auto_en;
   logic                    dir;
   logic                    hold;
   logic [NUM_CH*COL_W-1:0] colour;
   logic [NUM_CH-1:0]       wrap;

   modport master (
      output button, auto_en, dir, hold,
      input  colour, wrap
   );

   modport slave (
      input  button, auto_en, dir, hold,
      output colour, wrap
   );

endinterface

// File: rtl/colour_seq_channel.sv
// One channel: button edge detect, auto-step timer, colour and wrap registers.
module colour_seq_channel
   import colour_pkg::*;
#(
   parameter int unsigned COL_MIN = 1,
   parameter int unsigned COL_MAX = 6,
   parameter int unsigned PERIOD  = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    button,
   input  logic    auto_en,
   input  logic    dir,
   input  logic    hold,
   output colour_t colour,
   output logic    wrap
);

   localparam int unsigned TMR_W = $clog2(PERIOD);
   localparam colour_t     MIN_C = colour_t'(COL_MIN);
   localparam colour_t     MAX_C = colour_t'(COL_MAX);

   logic             btn_q;
   logic [TMR_W-1:0] timer_q, timer_d;
   colour_t          colour_q, colour_d;
   logic             wrap_q, wrap_d;

   logic  step_btn_c, lit_c, tick_c, in_range_c;
   next_t nxt_c;

   assign step_btn_c = button & ~btn_q;
   assign lit_c      = (colour_q != COL_OFF);
   assign tick_c     = auto_en & ~hold & lit_c & (timer_q == TMR_W'(PERIOD - 1));
   assign in_range_c = !lit_c || ((colour_q >= MIN_C) && (colour_q <= MAX_C));
   assign nxt_c      = next_colour(colour_q, dir, MIN_C, MAX_C);

   // Timer is frozen by hold; otherwise it restarts on a tick, a button step or when idle.
   always_comb begin
      timer_d = timer_q;
      if (!hold) begin
         if (!auto_en || !lit_c || step_btn_c || tick_c) begin
            timer_d = '0;
         end else begin
            timer_d = timer_q + TMR_W'(1);
         end
      end
   end

   // Out-of-range recovery beats hold and steps; a button step and a tick merge into one.
   always_comb begin
      colour_d = colour_q;
      wrap_d   = 1'b0;
      if (!in_range_c) begin
         colour_d = MIN_C;
      end else if (!hold && (step_btn_c || tick_c)) begin
         colour_d = nxt_c.colour;
         wrap_d   = nxt_c.wrap;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_q    <= 1'b0;
         timer_q  <= '0;
         colour_q <= COL_OFF;
         wrap_q   <= 1'b0;
      end else begin
         btn_q    <= button;
         timer_q  <= timer_d;
         colour_q <= colour_d;
         wrap_q   <= wrap_d;
      end
   end

   assign colour = colour_q;
   assign wrap   = wrap_q;

endmodule

// File: rtl/colour_sequencer.sv
// Multi-channel colour stepper driving one RGB panel; auto_en, dir and hold are shared.
module colour_sequencer
   import colour_pkg::*;
#(
   parameter int unsigned NUM_CH  = 2,
   parameter int unsigned COL_MIN = 1,
   parameter int unsigned COL_MAX = 6,
   parameter int unsigned PERIOD  = 4
) (
   input logic               clk,
   input logic               rst,
   colour_sequencer_if.slave bus
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      colour_seq_channel #(
         .COL_MIN (COL_MIN),
         .COL_MAX (COL_MAX),
         .PERIOD  (PERIOD)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .button  (bus.button[i]),
         .auto_en (bus.auto_en),
         .dir     (bus.dir),
         .hold    (bus.hold),
         .colour  (bus.colour[i*COL_W +: COL_W]),
         .wrap    (bus.wrap[i])
      );
   end

endmodule

// File: tb/tb_colour_sequencer.sv
// Directed and random checks of colour_sequencer against a per-channel behavioural model.
module tb_colour_sequencer;
   import colour_pkg::*;

   localparam int NUM_CH = 2;
   localparam int MIN    = 1;
   localparam int MAX    = 6;
   localparam int PERIOD = 4;
   localparam int NCOL   = MAX - MIN + 1;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   colour_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

   colour_sequencer #(
      .NUM_CH  (NUM_CH),
      .COL_MIN (MIN),
      .COL_MAX (MAX),
      .PERIOD  (PERIOD)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model state: colour code, cycles since last timer restart, button history, wrap flag.
   int m_col  [NUM_CH];
   int m_tmr  [NUM_CH];
   int m_wrap [NUM_CH];
   bit m_btn  [NUM_CH];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] dut_col(input int ch);
      return 32'(bus.colour[ch*COL_W +: COL_W]);
   endfunction

   task automatic check_all(input string tag);
      for (int ch = 0; ch < NUM_CH; ch++) begin
         check($sformatf("%s colour%0d", tag, ch), dut_col(ch), 32'(m_col[ch]));
         check($sformatf("%s wrap%0d", tag, ch), 32'(bus.wrap[ch]), 32'(m_wrap[ch]));
      end
   endtask

   task automatic model_reset();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         m_col[ch] = 0; m_tmr[ch] = 0; m_wrap[ch] = 0; m_btn[ch] = 1'b0;
      end
   endtask

   // Colours live on a ring of NCOL lit codes; a step moves one place around it.
   task automatic model_step();
      if (rst) begin
         model_reset();
         return;
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
         bit sb, lit, tick;
         int pos;
         sb   = bus.button[ch] && !m_btn[ch];
         lit  = (m_col[ch] != 0);
         tick = bus.auto_en && !bus.hold && lit && (m_tmr[ch] == PERIOD - 1);
         m_btn[ch]  = bus.button[ch];
         m_wrap[ch] = 0;
         if (!bus.hold)
            m_tmr[ch] = (!bus.auto_en || !lit || sb) ? 0 : (m_tmr[ch] + 1) % PERIOD;
         if (lit && (m_col[ch] < MIN || m_col[ch] > MAX)) begin
            m_col[ch] = MIN;
         end else if (!bus.hold && (sb || tick)) begin
            if (!lit) begin
               m_col[ch] = bus.dir ? MAX : MIN;
            end else begin
               pos = m_col[ch] - MIN + (bus.dir ? -1 : 1);
               m_wrap[ch] = (pos < 0 || pos >= NCOL) ? 1 : 0;
               m_col[ch]  = MIN + (pos + NCOL) % NCOL;
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all("cycle");
   endtask

   task automatic press(input int ch, output logic [31:0] c, output logic [31:0] w);
      bus.button[ch] = 1'b1;
      cycle();
      c = dut_col(ch);
      w = 32'(bus.wrap[ch]);
      bus.button[ch] = 1'b0;
      cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] c, w;
      int s0, s1;
      int exp_c [7] = '{1, 2, 3, 4, 5, 6, 1};

      rst = 1'b1;
      bus.button = '0; bus.auto_en = 1'b0; bus.dir = 1'b0; bus.hold = 1'b0;
      @(negedge clk);
      model_reset();
      check_all("reset");
      rst = 1'b0;

      // Seven manual steps up through the whole ring; only the 6->1 edge wraps.
      for (int k = 0; k < 7; k++) begin
         press(0, c, w);
         check($sformatf("up press%0d colour0", k), c, 32'(exp_c[k]));
         check($sformatf("up press%0d wrap0", k), w, (k == 6) ? 32'd1 : 32'd0);
      end
      check("ch1 idle", dut_col(1), 32'd0);

      // A level-high button is one step; release and re-press gives the next.
      do_reset();
      bus.button[0] = 1'b1;
      repeat (10) cycle();
      check("held button", dut_col(0), 32'd1);
      bus.button[0] = 1'b0;
      cycle();
      press(0, c, w);
      check("re-press", c, 32'd2);

      // Counting down from OFF enters at COL_MAX; 1 -> 6 wraps.
      do_reset();
      bus.dir = 1'b1;
      for (int k = 0; k < 3; k++) begin
         press(0, c, w);
         check($sformatf("down press%0d", k), c, 32'(MAX - k));
      end
      repeat (3) press(0, c, w);
      check("down at min", dut_col(0), 32'(MIN));
      press(0, c, w);
      check("down wrap colour", c, 32'(MAX));
      check("down wrap pulse", w, 32'd1);

      // Auto mode: ch1 steps every PERIOD cycles from 2.
      bus.dir = 1'b0;
      do_reset();
      press(1, c, w);
      press(1, c, w);
      check("ch1 start", c, 32'd2);
      bus.auto_en = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         cycle();
         if (k % PERIOD == 0) check($sformatf("auto k%0d", k), dut_col(1), 32'(2 + k / PERIOD));
      end
      check("auto ch0 off", dut_col(0), 32'd0);
      repeat (3) cycle();
      bus.button[1] = 1'b1;
      cycle();
      check("tick+button single", dut_col(1), 32'd6);
      bus.button[1] = 1'b0;
      repeat (3) cycle();
      check("timer restarted", dut_col(1), 32'd6);
      cycle();
      check("auto wrap colour", dut_col(1), 32'd1);
      check("auto wrap pulse", 32'(bus.wrap[1]), 32'd1);

      // Hold freezes everything; button activity during hold is not replayed.
      s0 = m_col[0]; s1 = m_col[1];
      bus.hold = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.button = 2'(k);
         cycle();
         check("hold colour1", dut_col(1), 32'(s1));
         check("hold wrap1", 32'(bus.wrap[1]), 32'd0);
      end
      bus.hold = 1'b0;
      cycle();
      bus.button = '0;
      repeat (2) cycle();
      check("post-hold ch0", dut_col(0), 32'(s0));
      check("post-hold ch1", dut_col(1), 32'(s1));

      // Async reset in the middle of a cycle.
      bus.auto_en = 1'b0;
      do_reset();
      repeat (5) press(0, c, w);
      check("pre-rst colour0", c, 32'd5);
      #1 rst = 1'b1;
      #1;
      check("async rst colour", 32'(bus.colour), 32'd0);
      check("async rst wrap", 32'(bus.wrap), 32'd0);
      model_reset();
      cycle();
      rst = 1'b0;
      press(0, c, w);
      check("re-entry after rst", c, 32'(MIN));

      // Illegal code 7 recovers to COL_MIN even under hold, without a wrap.
      bus.hold = 1'b1;
      force u_dut.g_ch[0].u_ch.colour_q = 3'd7;
      #1;
      check("forced colour", dut_col(0), 32'd7);
      release u_dut.g_ch[0].u_ch.colour_q;
      m_col[0] = 7;
      cycle();
      check("out of range recover", dut_col(0), 32'(MIN));
      check("out of range no wrap", 32'(bus.wrap[0]), 32'd0);
      bus.hold = 1'b0;

      // Random traffic against the model.
      do_reset();
      for (int k = 0; k < 400; k++) begin
         bus.button = 2'($urandom);
         if ($urandom_range(0, 15) == 0) bus.auto_en = ~bus.auto_en;
         if ($urandom_range(0, 7) == 0) bus.dir = ~bus.dir;
         bus.hold = ($urandom_range(0, 9) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
